// File: rtl/strobe_period_meter_if.sv
// Result channel of strobe_period_meter: measured period plus status flags
// and a valid/ready handshake. The master side drives the result.
interface strobe_period_meter_if #(
    parameter int WIDTH = 15
);
    logic [WIDTH-1:0] period;
    logic             period_ovf;
    logic             period_overrun;
    logic             period_valid;
    logic             period_ready;

    modport master (
        output period, period_ovf, period_overrun, period_valid,
        input  period_ready
    );

    modport slave (
        input  period, period_ovf, period_overrun, period_valid,
        output period_ready
    );
endinterface

// File: rtl/strobe_period_meter.sv
// Counts enable ticks between strobe pulses with a chunked registered-carry counter.
// Latency: result valid CHUNK_COUNT cycles after the strobe; optional min/max stats via STROBE_METER_MINMAX_EN.
// Backpressure: none upstream; an unaccepted result is overwritten and flagged by period_overrun.
module strobe_period_meter #(
    parameter int WIDTH   = 15,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  strobe_in,
`ifdef STROBE_METER_MINMAX_EN
    input  logic                  stats_clr,
    output logic [WIDTH-1:0]      period_min,
    output logic [WIDTH-1:0]      period_max,
`endif
    strobe_period_meter_if.master res
);
    localparam int ALU_WIDTH   = (WIDTH + LATENCY - 1) / LATENCY;
    localparam int CHUNK_COUNT = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;

    typedef enum logic {IDLE, MEASURE} state_t;

    typedef struct packed {
        logic                   vld;
        logic                   sat;
        logic [CHUNK_COUNT-1:0] pend;
        logic [WIDTH-1:0]       val;
    } stage_t;

    // Adds cin into chunk k only; returns {carry_out, updated vector}.
    function automatic logic [WIDTH:0] inc_chunk(input logic [WIDTH-1:0] v,
                                                 input int k, input logic cin);
        logic [WIDTH-1:0] r;
        logic             c;
        r = v;
        c = cin;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= k * ALU_WIDTH && i < (k + 1) * ALU_WIDTH) begin
                r[i] = v[i] ^ c;
                c    = v[i] & c;
            end
        end
        return {c, r};
    endfunction

    function automatic stage_t fold(input stage_t s, input int k);
        stage_t           r;
        logic [WIDTH:0]   t;
        r         = s;
        t         = inc_chunk(s.val, k, s.pend[k]);
        r.val     = t[WIDTH-1:0];
        r.pend[k] = 1'b0;
        if (k == CHUNK_COUNT - 1)
            r.sat = s.sat | t[WIDTH];
        else
            r.pend[(k + 1) % CHUNK_COUNT] = s.pend[(k + 1) % CHUNK_COUNT] | t[WIDTH];
        return r;
    endfunction

    state_t                 state, state_nx;
    logic [WIDTH-1:0]       cnt, cnt_nx;
    logic [CHUNK_COUNT-1:0] cr, cr_nx;
    logic                   sat, top_co;
    logic [WIDTH:0]         cnt_t;
    stage_t                 snap, fin_in, fin;
    logic                   res_ovf;
    logic [WIDTH-1:0]       res_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && strobe_in)
            state_nx = MEASURE;
    end

    // Carries from chunk k land in cr[k+1] and are added one cycle later.
    always_comb begin
        cnt_nx = cnt;
        cr_nx  = '0;
        top_co = 1'b0;
        cnt_t  = '0;
        for (int k = 0; k < CHUNK_COUNT; k++) begin
            cnt_t  = inc_chunk(cnt_nx, k, (k == 0) ? enable : cr[k]);
            cnt_nx = cnt_t[WIDTH-1:0];
            if (k == CHUNK_COUNT - 1)
                top_co = cnt_t[WIDTH];
            else
                cr_nx[(k + 1) % CHUNK_COUNT] = cnt_t[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            cr  <= '0;
            sat <= 1'b0;
        end else if (state != MEASURE || strobe_in) begin
            cnt <= '0;
            cr  <= '0;
            sat <= 1'b0;
        end else if (!sat) begin
            if (top_co) begin
                cnt <= '1;
                cr  <= '0;
                sat <= 1'b1;
            end else begin
                cnt <= cnt_nx;
                cr  <= cr_nx;
            end
        end
    end

    // Snapshot includes this cycle's tick, so the strobe cycle counts toward its own period.
    always_comb begin
        snap      = '0;
        snap.vld  = (state == MEASURE) && strobe_in;
        snap.sat  = sat | top_co;
        snap.val  = snap.sat ? '1 : cnt_nx;
        snap.pend = snap.sat ? '0 : cr_nx;
    end

    generate
        if (CHUNK_COUNT == 1) begin : g_direct
            assign fin_in = snap;
        end else begin : g_pipe
            stage_t st [CHUNK_COUNT-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < CHUNK_COUNT - 1; j++)
                        st[j] <= '0;
                end else begin
                    st[0] <= snap;
                    for (int j = 1; j < CHUNK_COUNT - 1; j++)
                        st[j] <= fold(st[j-1], j);
                end
            end
            assign fin_in = st[CHUNK_COUNT-2];
        end
    endgenerate

    assign fin     = fold(fin_in, CHUNK_COUNT - 1);
    assign res_ovf = fin.sat | (&fin.val);
    assign res_val = res_ovf ? '1 : fin.val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res.period         <= '0;
            res.period_ovf     <= 1'b0;
            res.period_overrun <= 1'b0;
            res.period_valid   <= 1'b0;
        end else if (fin.vld) begin
            res.period         <= res_val;
            res.period_ovf     <= res_ovf;
            res.period_valid   <= 1'b1;
            res.period_overrun <= res.period_valid & ~res.period_ready;
        end else if (res.period_valid && res.period_ready) begin
            res.period_valid   <= 1'b0;
            res.period_overrun <= 1'b0;
        end
    end

`ifdef STROBE_METER_MINMAX_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_min <= '1;
            period_max <= '0;
        end else if (stats_clr) begin
            period_min <= '1;
            period_max <= '0;
        end else if (fin.vld) begin
            if (res_val < period_min) period_min <= res_val;
            if (res_val > period_max) period_max <= res_val;
        end
    end
`endif
endmodule
